// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM states, requester ids, defaults.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   localparam int DEF_DATA_W     = 16;
   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_DEPTH      = 1024;
   localparam int DEF_ACCESS_CYC = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; ptr names the requester favoured on a tie.
// Latency: purely combinational.
// Backpressure: none; the parent only samples the grant while idle.
module rr_arbiter2
   import ram_arb_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  logic ptr,
   output logic gnt_vld,
   output logic gnt_id
);

   // Pick the lone requester, or the favoured one when both ask.
   always_comb begin
      gnt_vld = req_a | req_b;
      gnt_id  = REQ_A;
      if (req_a && req_b) begin
         gnt_id = ptr;
      end else if (req_b) begin
         gnt_id = REQ_B;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between requesters A and B with round-robin grants.
// Latency: ACK appears ACCESS_CYC+2 cycles after REQ is sampled idle; out-of-range in 2.
// Backpressure: REQ is held until ACK; a waiting requester stalls while the other is served.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ACCESS_CYC = DEF_ACCESS_CYC
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              A_REQ,
   input  logic              A_WE,
   input  logic [ADDR_W-1:0] A_ADDR,
   input  logic [DATA_W-1:0] A_WDATA,
   output logic              A_ACK,
   output logic              A_ERR,
   output logic [DATA_W-1:0] A_RDATA,
   input  logic              B_REQ,
   input  logic              B_WE,
   input  logic [ADDR_W-1:0] B_ADDR,
   input  logic [DATA_W-1:0] B_WDATA,
   output logic              B_ACK,
   output logic              B_ERR,
   output logic [DATA_W-1:0] B_RDATA,
   output logic              RAM_CS,
   output logic              RAM_RD,
   output logic              RAM_WR,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [DATA_W-1:0] RAM_DIN,
   input  logic [DATA_W-1:0] RAM_DOUT,
   output logic              BUSY
);

   // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      CNT_INIT = 4'(ACCESS_CYC - 1);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                ptr_q, ptr_d;
   logic                win_q, win_d;
   logic                we_q, we_d;
   logic                err_q, err_d;
   logic                ram_cs_q, ram_cs_d;
   logic                ram_rd_q, ram_rd_d;
   logic                ram_wr_q, ram_wr_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_din_q, ram_din_d;
   logic                a_ack_q, a_ack_d;
   logic                a_err_q, a_err_d;
   logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
   logic                b_ack_q, b_ack_d;
   logic                b_err_q, b_err_d;
   logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
   logic                busy_q, busy_d;

   logic                gnt_vld;
   logic                gnt_id;
   logic                cmd_we;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_wdata;
   logic                cmd_in_range;

   rr_arbiter2 u_rr (
      .req_a   (A_REQ),
      .req_b   (B_REQ),
      .ptr     (ptr_q),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

   // Steer the candidate winner's command and range-check its address.
   always_comb begin
      cmd_we       = (gnt_id == REQ_B) ? B_WE    : A_WE;
      cmd_addr     = (gnt_id == REQ_B) ? B_ADDR  : A_ADDR;
      cmd_wdata    = (gnt_id == REQ_B) ? B_WDATA : A_WDATA;
      cmd_in_range = ({1'b0, cmd_addr} < DEPTH_L);
   end

   // Next-state and next-output logic; every output is a flop loaded from here.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      win_d      = win_q;
      we_d       = we_q;
      err_d      = err_q;
      ram_cs_d   = ram_cs_q;
      ram_rd_d   = ram_rd_q;
      ram_wr_d   = ram_wr_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      a_ack_d    = 1'b0;
      a_err_d    = 1'b0;
      a_rdata_d  = a_rdata_q;
      b_ack_d    = 1'b0;
      b_err_d    = 1'b0;
      b_rdata_d  = b_rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               win_d = gnt_id;
               we_d  = cmd_we;
               cnt_d = CNT_INIT;
               if (cmd_in_range) begin
                  // Strobes rise together with the ACCESS state.
                  err_d      = 1'b0;
                  state_d    = ST_ACCESS;
                  ram_cs_d   = 1'b1;
                  ram_wr_d   = cmd_we;
                  ram_rd_d   = !cmd_we;
                  ram_addr_d = cmd_addr;
                  ram_din_d  = cmd_wdata;
               end else begin
                  // Bad address: skip the RAM entirely and report.
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end

         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               if (!we_q) begin
                  if (win_q == REQ_B) begin
                     b_rdata_d = RAM_DOUT;
                  end else begin
                     a_rdata_d = RAM_DOUT;
                  end
               end
               state_d  = ST_DONE;
               ram_cs_d = 1'b0;
               ram_rd_d = 1'b0;
               ram_wr_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_DONE: begin
            if (win_q == REQ_B) begin
               b_ack_d = 1'b1;
               b_err_d = err_q;
               if (err_q && !we_q) begin
                  b_rdata_d = '0;
               end
            end else begin
               a_ack_d = 1'b1;
               a_err_d = err_q;
               if (err_q && !we_q) begin
                  a_rdata_d = '0;
               end
            end
            ptr_d   = ~win_q;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered busy mirrors the state being entered.
   always_comb begin
      busy_d = (state_d != ST_IDLE);
   end

   // Single state register; reset drops the strobes and discards any command.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         ptr_q      <= REQ_A;
         win_q      <= REQ_A;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         ram_cs_q   <= 1'b0;
         ram_rd_q   <= 1'b0;
         ram_wr_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         a_ack_q    <= 1'b0;
         a_err_q    <= 1'b0;
         a_rdata_q  <= '0;
         b_ack_q    <= 1'b0;
         b_err_q    <= 1'b0;
         b_rdata_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         win_q      <= win_d;
         we_q       <= we_d;
         err_q      <= err_d;
         ram_cs_q   <= ram_cs_d;
         ram_rd_q   <= ram_rd_d;
         ram_wr_q   <= ram_wr_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         a_ack_q    <= a_ack_d;
         a_err_q    <= a_err_d;
         a_rdata_q  <= a_rdata_d;
         b_ack_q    <= b_ack_d;
         b_err_q    <= b_err_d;
         b_rdata_q  <= b_rdata_d;
         busy_q     <= busy_d;
      end
   end

   assign A_ACK    = a_ack_q;
   assign A_ERR    = a_err_q;
   assign A_RDATA  = a_rdata_q;
   assign B_ACK    = b_ack_q;
   assign B_ERR    = b_err_q;
   assign B_RDATA  = b_rdata_q;
   assign RAM_CS   = ram_cs_q;
   assign RAM_RD   = ram_rd_q;
   assign RAM_WR   = ram_wr_q;
   assign RAM_ADDR = ram_addr_q;
   assign RAM_DIN  = ram_din_q;
   assign BUSY     = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, reference memory, directed and random accesses.
// Latency: expects ACK ACCESS_CYC+2 cycles after a sampled request, 2 for bad addresses.
// Backpressure: requesters hold REQ until they see ACK, then drop it.
module tb_ram_port_arbiter;

   localparam int ACC = 1;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        A_REQ, A_WE, B_REQ, B_WE;
   logic [15:0] A_ADDR, A_WDATA, B_ADDR, B_WDATA;
   logic        A_ACK, A_ERR, B_ACK, B_ERR;
   logic [15:0] A_RDATA, B_RDATA;
   logic        RAM_CS, RAM_RD, RAM_WR, BUSY;
   logic [15:0] RAM_ADDR, RAM_DIN, RAM_DOUT;

   int n_tests = 0;
   int n_fail  = 0;

   // Environment RAM plus strobe monitor
   logic [15:0] ram_mem [0:1023];
   int          cs_total = 0;
   int          rd_total = 0;
   int          wr_total = 0;
   logic [15:0] last_cs_addr = 16'h0;
   logic [15:0] last_cs_din  = 16'h0;
   logic        strobe_bad   = 1'b0;

   // Reference model state
   logic [15:0] ref_mem [0:1023];
   logic [15:0] last_rd [2];

   ram_port_arbiter #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .ACCESS_CYC(ACC)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
      .A_ACK(A_ACK), .A_ERR(A_ERR), .A_RDATA(A_RDATA),
      .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
      .B_ACK(B_ACK), .B_ERR(B_ERR), .B_RDATA(B_RDATA),
      .RAM_CS(RAM_CS), .RAM_RD(RAM_RD), .RAM_WR(RAM_WR),
      .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT),
      .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   // Synchronous-write, asynchronous-read RAM
   always @(posedge CLK) begin
      if (RAM_CS && RAM_WR) ram_mem[RAM_ADDR[9:0]] <= RAM_DIN;
   end
   assign RAM_DOUT = ram_mem[RAM_ADDR[9:0]];

   // Count strobe cycles mid-cycle and flag illegal strobe combinations
   always @(negedge CLK) begin
      if (RAM_CS) begin
         cs_total++;
         if (RAM_RD) rd_total++;
         if (RAM_WR) wr_total++;
         last_cs_addr = RAM_ADDR;
         last_cs_din  = RAM_DIN;
      end
      if ((RAM_RD && RAM_WR) || (!RAM_CS && (RAM_RD || RAM_WR))) strobe_bad = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One request from a single requester, checked against the reference model
   task automatic do_access(input logic who, input logic we, input logic [15:0] addr,
                            input logic [15:0] wdata);
      int          lat;
      logic        got;
      logic        ok;
      int          cs0, rd0, wr0;
      logic        obs_err;
      logic [15:0] obs_rd, exp_rd;
      int          idx;
      ok  = (addr < 16'd1024);
      idx = int'(addr[9:0]);
      cs0 = cs_total; rd0 = rd_total; wr0 = wr_total;
      if (who) begin
         B_REQ = 1'b1; B_WE = we; B_ADDR = addr; B_WDATA = wdata;
      end else begin
         A_REQ = 1'b1; A_WE = we; A_ADDR = addr; A_WDATA = wdata;
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(negedge CLK); #1;
         lat++;
         got = who ? B_ACK : A_ACK;
      end
      obs_err = who ? B_ERR : A_ERR;
      obs_rd  = who ? B_RDATA : A_RDATA;
      A_REQ = 1'b0;
      B_REQ = 1'b0;
      if (!ok)     exp_rd = we ? last_rd[who] : 16'h0000;
      else if (we) exp_rd = last_rd[who];
      else         exp_rd = ref_mem[idx];
      check($sformatf("ack_seen@%0h", addr), got, 1'b1);
      check($sformatf("latency@%0h", addr), lat, ok ? ACC + 2 : 2);
      check($sformatf("err@%0h", addr), obs_err, !ok);
      check($sformatf("rdata@%0h", addr), obs_rd, exp_rd);
      check($sformatf("cs_cycles@%0h", addr), cs_total - cs0, ok ? ACC : 0);
      check($sformatf("rd_cycles@%0h", addr), rd_total - rd0, (ok && !we) ? ACC : 0);
      check($sformatf("wr_cycles@%0h", addr), wr_total - wr0, (ok && we) ? ACC : 0);
      if (ok) check($sformatf("ram_addr@%0h", addr), last_cs_addr, addr);
      if (ok && we) check($sformatf("ram_din@%0h", addr), last_cs_din, wdata);
      if (ok && we) ref_mem[idx] = wdata;
      last_rd[who] = exp_rd;
   endtask

   initial begin
      int          c, k, busy_low, acks, exp_who, cs0;
      logic        rw, rwho;
      logic [15:0] raddr;

      RST_N = 1'b0;
      A_REQ = 1'b0; A_WE = 1'b0; A_ADDR = 16'h0; A_WDATA = 16'h0;
      B_REQ = 1'b0; B_WE = 1'b0; B_ADDR = 16'h0; B_WDATA = 16'h0;
      last_rd[0] = 16'h0;
      last_rd[1] = 16'h0;

      // Reset values
      @(negedge CLK); @(negedge CLK); #1;
      check("rst_strobes", {A_ACK, A_ERR, B_ACK, B_ERR, RAM_CS, RAM_RD, RAM_WR, BUSY}, 8'h00);
      check("rst_ram_addr", RAM_ADDR, 16'h0000);
      check("rst_ram_din", RAM_DIN, 16'h0000);
      check("rst_a_rdata", A_RDATA, 16'h0000);
      check("rst_b_rdata", B_RDATA, 16'h0000);
      RST_N = 1'b1;
      @(negedge CLK); #1;

      // Directed write then read-back by A
      do_access(1'b0, 1'b1, 16'h0005, 16'h00AA);
      do_access(1'b0, 1'b0, 16'h0005, 16'h0000);
      check("a_read_literal", A_RDATA, 16'h00AA);

      // Reset during ACCESS: strobes drop at once, no ACK, pointer back to A
      A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 16'h0007; A_WDATA = 16'h1234;
      @(negedge CLK); #1;
      check("midrst_cs_before", {RAM_CS, RAM_WR}, 2'b11);
      #1 RST_N = 1'b0;
      #1;
      check("midrst_cs_after", {RAM_CS, RAM_WR, RAM_RD, BUSY}, 4'b0000);
      A_REQ = 1'b0;
      cs0  = cs_total;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK); #1;
         if (i == 2) RST_N = 1'b1;
         if (A_ACK || B_ACK) acks++;
      end
      check("midrst_no_ack", acks, 0);
      check("midrst_no_cs", cs_total - cs0, 0);
      last_rd[0] = 16'h0;
      last_rd[1] = 16'h0;

      // Both requesters held: strict alternation starting with A
      A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 16'h0005;
      B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 16'h0005;
      c = 0; k = 0; busy_low = 0;
      while (k < 4 && c < 40) begin
         @(negedge CLK); #1;
         c++;
         if (!BUSY) busy_low++;
         if (A_ACK || B_ACK) begin
            exp_who = k % 2;
            check($sformatf("both_a_ack%0d", k), A_ACK, exp_who == 0);
            check($sformatf("both_b_ack%0d", k), B_ACK, exp_who == 1);
            check($sformatf("both_time%0d", k), c, (ACC + 2) * (k + 1));
            check($sformatf("both_rdata%0d", k), (exp_who == 1) ? B_RDATA : A_RDATA, ref_mem[5]);
            k++;
         end
      end
      A_REQ = 1'b0;
      B_REQ = 1'b0;
      check("both_ack_count", k, 4);
      check("both_busy_low", busy_low, 4);
      last_rd[0] = ref_mem[5];
      last_rd[1] = ref_mem[5];

      // Out-of-range accesses: no RAM activity, error reported
      do_access(1'b1, 1'b0, 16'h0400, 16'h0000);
      check("b_err_rdata_literal", B_RDATA, 16'h0000);
      do_access(1'b0, 1'b1, 16'hFFFF, 16'h5555);
      do_access(1'b0, 1'b0, 16'h03FF, 16'h0000);

      // Fill by A, full read-back by B
      for (int kk = 0; kk < 1024; kk++) do_access(1'b0, 1'b1, 16'(kk), 16'((2 * kk) % 256));
      for (int kk = 0; kk < 1024; kk++) begin
         do_access(1'b1, 1'b0, 16'(kk), 16'h0000);
         if (kk == 200)  check("b_read_200", B_RDATA, 16'h0090);
         if (kk == 1023) check("b_read_1023", B_RDATA, 16'h00FE);
      end

      // Random single-requester traffic with occasional bad addresses
      for (int r = 0; r < 300; r++) begin
         rwho = 1'($urandom_range(0, 1));
         rw   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) raddr = 16'($urandom_range(1024, 65535));
         else                           raddr = 16'($urandom_range(0, 1023));
         do_access(rwho, rw, raddr, 16'($urandom));
      end

      check("strobe_rules", strobe_bad, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
